automatic_washing_machine: RTL and testbench
============================================

AUTOMATIC_WASHING_MACHINE -- requirements
Module: automatic_washing_machine

Interface
- Single clock; reset is asynchronous and active-high.
- REQ-001 The block SHALL have these ports, clock and reset first, all 1 bit:
  - clk  input  1  clock; all state updates on the rising edge.
  - reset  input  1  asynchronous, active-high reset.
  - door_close  input  1  door-closed sensor.
  - start  input  1  user start request, level.
  - filled  input  1  water-level-full sensor.
  - detergent_added  input  1  detergent-dispensed indication.
  - cycle_timeout  input  1  wash or rinse agitation timer expired.
  - drained  input  1  water-level-empty sensor.
  - spin_timeout  input  1  spin timer expired.
  - door_lock  output  1  door lock solenoid.
  - motor_on  output  1  drum motor.
  - fill_value_on  output  1  fill valve.
  - drain_value_on  output  1  drain valve.
  - done  output  1  program complete.
  - soap_wash  output  1  soap pass completed (detergent added).
  - water_wash  output  1  rinse pass in progress or completed.

Function
- REQ-002 All inputs SHALL be level-sensitive and sampled on the rising clk edge; each state transition SHALL take exactly one clock.
- REQ-003 The block SHALL be a Moore FSM with 7 states: IDLE, FILL, DETERGENT, WASH, DRAIN, SPIN, DONE.
- REQ-004 door_lock, motor_on, fill_value_on, drain_value_on and done SHALL be decoded from the state register only, with no combinational input-to-output path.
- REQ-005 soap_wash and water_wash SHALL be registered phase flags.
- REQ-006 Output decode per state (any output not listed is 0):
  - IDLE: none.
  - FILL: door_lock, fill_value_on.
  - DETERGENT: door_lock.
  - WASH: door_lock, motor_on.
  - DRAIN: door_lock, drain_value_on.
  - SPIN: door_lock, motor_on, drain_value_on.
  - DONE: done.
- REQ-007 IDLE -> FILL when start=1 and door_close=1; otherwise stay in IDLE.
- REQ-008 FILL -> DETERGENT when filled=1 and soap_wash=0.
- REQ-009 FILL -> WASH when filled=1 and soap_wash=1, so the rinse pass adds no detergent.
- REQ-010 DETERGENT -> WASH when detergent_added=1, setting soap_wash to 1 on the same edge.
- REQ-011 WASH -> DRAIN when cycle_timeout=1.
- REQ-012 DRAIN -> FILL when drained=1 and water_wash=0, setting water_wash to 1 on the same edge (start rinse pass).
- REQ-013 DRAIN -> SPIN when drained=1 and water_wash=1.
- REQ-014 SPIN -> DONE when spin_timeout=1.
- REQ-015 DONE -> IDLE when start=0, clearing soap_wash and water_wash on the same edge; while start=1 the FSM stays in DONE with done=1.
- REQ-016 In every state other than IDLE, only the input named in that state's transition SHALL be evaluated; all other inputs SHALL be ignored.
- REQ-017 Deassertion of door_close after leaving IDLE SHALL be ignored (the door is locked).
- REQ-018 Deassertion of start after leaving IDLE SHALL be ignored until DONE.
- REQ-019 An input held high across several states SHALL advance the FSM one state per clock, never more than one.
- REQ-020 Unused state encodings SHALL recover to IDLE on the next clock, with flags cleared.

Reset
- REQ-021 While reset=1 the block SHALL immediately, asynchronously, enter IDLE and drive all seven outputs to 0, including soap_wash and water_wash.
- REQ-022 Reset asserted mid-cycle (e.g. in WASH or SPIN) SHALL abort the program, unlock the door and stop motor and valves with no completion pulse.
- REQ-023 After reset is released, the first transition SHALL occur on the first rising edge where the REQ-007 condition holds.

Verification
- REQ-024 Reset, then start=1 and door_close=1 -> next edge FILL: door_lock=1, fill_value_on=1, motor_on=0, done=0.
- REQ-025 Full program with inputs raised one per phase -> state sequence IDLE, FILL, DETERGENT, WASH, DRAIN, FILL, WASH, DRAIN, SPIN, DONE; soap_wash=1 from the first WASH; water_wash=1 from the second FILL; done=1 only in DONE.
- REQ-026 All sensor inputs held at 1 after start -> FSM advances exactly one state per clock, reaching DONE 9 edges after leaving IDLE.
- REQ-027 start=1 with door_close=0 for 10 clocks -> remains in IDLE with all outputs 0.
- REQ-028 reset pulsed while in SPIN -> outputs immediately 0, no done pulse; the subsequent program restarts with soap_wash=0 and water_wash=0.
- REQ-029 In DONE, drop start -> next edge IDLE with done=0, soap_wash=0, water_wash=0; door_close toggled mid-WASH -> no effect on state or door_lock.

Source files
------------

// File: rtl/automatic_washing_machine.sv
// Washing-machine program sequencer: Moore FSM, one state per clock, outputs decoded from state.
// The soap_wash/water_wash phase flags are registered and let FILL/DRAIN tell the soap pass from the rinse pass.
module automatic_washing_machine (
  input  logic clk,
  input  logic reset,
  input  logic door_close,
  input  logic start,
  input  logic filled,
  input  logic detergent_added,
  input  logic cycle_timeout,
  input  logic drained,
  input  logic spin_timeout,
  output logic door_lock,
  output logic motor_on,
  output logic fill_value_on,
  output logic drain_value_on,
  output logic done,
  output logic soap_wash,
  output logic water_wash
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_DETERGENT = 3'd2,
    S_WASH      = 3'd3,
    S_DRAIN     = 3'd4,
    S_SPIN      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_soap;
  logic   r_water;
  logic   w_soap_nxt;
  logic   w_water_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_soap  <= 1'b0;
      r_water <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_soap  <= w_soap_nxt;
      r_water <= w_water_nxt;
    end
  end

  // Each state looks only at its own exit condition; everything else is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_soap_nxt  = r_soap;
    w_water_nxt = r_water;
    case (r_state)
      S_IDLE: begin
        if (start && door_close) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        if (filled) w_state_nxt = r_soap ? S_WASH : S_DETERGENT;
      end
      S_DETERGENT: begin
        if (detergent_added) begin
          w_state_nxt = S_WASH;
          w_soap_nxt  = 1'b1;
        end
      end
      S_WASH: begin
        if (cycle_timeout) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drained) begin
          if (r_water) begin
            w_state_nxt = S_SPIN;
          end else begin
            w_state_nxt = S_FILL;
            w_water_nxt = 1'b1;
          end
        end
      end
      S_SPIN: begin
        if (spin_timeout) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!start) begin
          w_state_nxt = S_IDLE;
          w_soap_nxt  = 1'b0;
          w_water_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_soap_nxt  = 1'b0;
        w_water_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_value_on  = 1'b0;
    drain_value_on = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_FILL: begin
        door_lock     = 1'b1;
        fill_value_on = 1'b1;
      end
      S_DETERGENT: door_lock = 1'b1;
      S_WASH: begin
        door_lock = 1'b1;
        motor_on  = 1'b1;
      end
      S_DRAIN: begin
        door_lock      = 1'b1;
        drain_value_on = 1'b1;
      end
      S_SPIN: begin
        door_lock      = 1'b1;
        motor_on       = 1'b1;
        drain_value_on = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign soap_wash  = r_soap;
  assign water_wash = r_water;

endmodule

// File: tb/tb_automatic_washing_machine.sv
// Scoreboard bench: driver pushes expected outputs from a program-step model; monitor pops and compares each cycle.
module tb_automatic_washing_machine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic door_close = 1'b0;
  logic start = 1'b0;
  logic filled = 1'b0;
  logic detergent_added = 1'b0;
  logic cycle_timeout = 1'b0;
  logic drained = 1'b0;
  logic spin_timeout = 1'b0;
  logic door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash;

  automatic_washing_machine dut (
    .clk(clk), .reset(reset), .door_close(door_close), .start(start), .filled(filled),
    .detergent_added(detergent_added), .cycle_timeout(cycle_timeout), .drained(drained),
    .spin_timeout(spin_timeout), .door_lock(door_lock), .motor_on(motor_on),
    .fill_value_on(fill_value_on), .drain_value_on(drain_value_on), .done(done),
    .soap_wash(soap_wash), .water_wash(water_wash)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int step  = 0;     // position in the program: 0 idle .. 9 done
  logic [6:0] sb[$];

  // Program positions: 0 IDLE,1 FILL,2 DETERGENT,3 WASH,4 DRAIN,5 FILL,6 WASH,7 DRAIN,8 SPIN,9 DONE.
  // Vector order: {door_lock, motor_on, fill, drain, done, soap_wash, water_wash}.
  function automatic logic [6:0] expect_out(input int p);
    logic [4:0] act;
    case (p)
      1, 5:    act = 5'b10100;
      2:       act = 5'b10000;
      3, 6:    act = 5'b11000;
      4, 7:    act = 5'b10010;
      8:       act = 5'b11010;
      9:       act = 5'b00001;
      default: act = 5'b00000;
    endcase
    return {act, (p >= 3), (p >= 5)};
  endfunction

  function automatic int advance(input int p, input logic s, input logic d, input logic f,
                                 input logic det, input logic ct, input logic dr, input logic st);
    logic go;
    case (p)
      0:       go = s & d;
      1, 5:    go = f;
      2:       go = det;
      3, 6:    go = ct;
      4, 7:    go = dr;
      8:       go = st;
      9:       go = ~s;
      default: go = 1'b0;
    endcase
    if (!go) return p;
    return (p == 9) ? 0 : p + 1;
  endfunction

  function automatic logic [6:0] dut_out();
    return {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b want %b (step %0d)", name, $time, act, exp, step);
    end
  endtask

  task automatic cyc(input logic s, input logic d, input logic f, input logic det,
                     input logic ct, input logic dr, input logic st, input logic rst_pulse);
    @(negedge clk);
    if (rst_pulse) begin
      reset = 1'b1;
      #1;
      check("async_reset", dut_out(), 7'b0);
      step = 0;
      #1;
      reset = 1'b0;
    end
    start = s; door_close = d; filled = f; detergent_added = det;
    cycle_timeout = ct; drained = dr; spin_timeout = st;
    step = advance(step, s, d, f, det, ct, dr, st);
    sb.push_back(expect_out(step));
  endtask

  // Raise one sensor (1 filled,2 detergent,3 cycle,4 drained,5 spin) with start/door arbitrary.
  task automatic sensor(input int which);
    logic s, d;
    s = 1'($urandom_range(0, 1));
    d = 1'($urandom_range(0, 1));
    cyc(s, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, ~d, which == 1, which == 2, which == 3, which == 4, which == 5, 1'b0);
  endtask

  initial begin : monitor
    logic [6:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("cycle", dut_out(), exp);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not end, got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    #1;
    check("reset_state", dut_out(), 7'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Door open: start alone must never leave idle.
    repeat (10) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Full program, one sensor per phase, door and start wiggling once locked.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sensor(1); sensor(2); sensor(3); sensor(4);
    sensor(1); sensor(3); sensor(4); sensor(5);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Everything held high: exactly one state per clock, DONE on the 9th edge.
    repeat (12) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reach SPIN, then reset mid-spin; the restart must show cleared flags.
    repeat (8) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 70,
          $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40,
          $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40,
          $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 2);
    end

    @(posedge clk);
    #3;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
